// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access unit between the CPU memory stage and
// the SoC data bus. Accepts one load/store at a time, issues a single
// word-aligned bus transaction with byte enables, waits for bus_ack, and
// returns sign/zero-extended load data. Misaligned and illegal requests are
// answered without touching the bus.
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS that sees no
// bus_ack within TIMEOUT_CYCLES cycles (err_code 10).
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    state_t      state;
    logic [2:0]  load_type_q;   // load formatting of the in-flight access
    logic [1:0]  offset_q;      // byte lane of the in-flight access
    logic        is_load_q;

    size_t       req_size;
    logic        req_illegal;
    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Extract the addressed lane(s) of the bus word and extend to 32 bits.
    function automatic logic [31:0] format_load(input logic [2:0] lt, input logic [1:0] ofs,
                                                input logic [31:0] data);
        logic [15:0] half;
        logic [7:0]  byte_v;
        half   = ofs[1] ? data[31:16] : data[15:0];
        byte_v = data[8*ofs +: 8];
        case (lt)
            3'b001:  format_load = {{16{half[15]}}, half};
            3'b010:  format_load = {16'h0, half};
            3'b011:  format_load = {{24{byte_v[7]}}, byte_v};
            3'b100:  format_load = {24'h0, byte_v};
            default: format_load = data;
        endcase
    endfunction

    // Decode the incoming request: access size, legality, alignment, lanes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        req_size    = SZ_WORD;
        req_illegal = 1'b0;
        if (mem_read) begin
            case (load_type)
                3'b000:         req_size = SZ_WORD;
                3'b001, 3'b010: req_size = SZ_HALF;
                3'b011, 3'b100: req_size = SZ_BYTE;
                default:        req_illegal = 1'b1;
            endcase
        end else begin
            case (store_type)
                2'b00:   req_size = SZ_WORD;
                2'b01:   req_size = SZ_HALF;
                2'b10:   req_size = SZ_BYTE;
                default: req_illegal = 1'b1;
            endcase
        end
        if (mem_read && mem_write) req_illegal = 1'b1;

        req_misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                         ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));

        case (req_size)
            SZ_HALF: begin
                req_be    = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = wdata;
            end
        endcase
    end

    // Request/bus/response FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            load_type_q <= '0;
            offset_q    <= '0;
            is_load_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        load_type_q <= load_type;
                        offset_q    <= addr[1:0];
                        is_load_q   <= mem_read;
                        rdata       <= '0;
                        if (!mem_read && !mem_write && !req_illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else if (req_illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            err_code   <= ERR_ILLEGAL;
                        end else if (req_misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            err_code   <= ERR_MISALIGN;
                        end else begin
                            state     <= ACCESS;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= req_be;
                            bus_wdata <= mem_write ? req_wdata : 32'h0;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        rdata      <= is_load_q ? format_load(load_type_q, offset_q, bus_rdata) : 32'h0;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_be     <= '0;
                        bus_wdata  <= '0;
                    end
`ifdef MEM_TIMEOUT_EN
                    // An ack on the limit cycle takes priority over the abort.
                    else if (wait_cnt + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        err        <= 1'b1;
                        err_code   <= ERR_TIMEOUT;
                        rdata      <= '0;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_be     <= '0;
                        bus_wdata  <= '0;
                        wait_cnt   <= wait_cnt + CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    rdata      <= '0;
                    err        <= 1'b0;
                    err_code   <= ERR_NONE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit. Expected
// responses are queued when a request is driven and compared by a monitor
// when resp_valid is seen. Define MEM_TIMEOUT_EN to also exercise the
// timeout path (built with TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  store_type = 2'b00;
    logic [2:0]  load_type = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    mem_access_unit #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .store_type(store_type), .load_type(load_type),
        .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .err(err), .err_code(err_code),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every completion against the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", rdata, e.rdata);
                check("resp_err", {31'h0, err}, {31'h0, e.err});
                check("resp_code", {30'h0, err_code}, {30'h0, e.code});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and play the bus side; delay = extra wait cycles before ack.
    task automatic do_req(input string tag, input logic mr, input logic mw,
                          input logic [1:0] st, input logic [2:0] lt,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                          input int delay, input logic go_bus,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata, input logic [1:0] e_code);
        exp_t e;
        for (int i = 0; i < 20 && !req_ready; i++) next_cycle();
        check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
        e.rdata = e_rdata;
        e.err   = (e_code != 2'b00);
        e.code  = e_code;
        sb.push_back(e);
        req_valid = 1'b1; mem_read = mr; mem_write = mw;
        store_type = st; load_type = lt; addr = a; wdata = wd;
        next_cycle();
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (go_bus) begin
            check({tag, "_bus_req"}, {31'h0, bus_req}, 32'd1);
            check({tag, "_resp_early"}, {31'h0, resp_valid}, 32'd0);
            check({tag, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
            check({tag, "_bus_be"}, {28'h0, bus_be}, {28'h0, e_be});
            check({tag, "_bus_we"}, {31'h0, bus_we}, {31'h0, mw});
            if (mw) check({tag, "_bus_wdata"}, bus_wdata, e_wdata);
            for (int i = 0; i < delay; i++) begin
                next_cycle();
                check({tag, "_hold_req"}, {31'h0, bus_req}, 32'd1);
                check({tag, "_hold_be"}, {28'h0, bus_be}, {28'h0, e_be});
            end
            bus_ack = 1'b1; bus_rdata = brd;
            next_cycle();
            bus_ack = 1'b0; bus_rdata = 32'hDEAD_DEAD;
            check({tag, "_req_drop"}, {31'h0, bus_req}, 32'd0);
        end else begin
            check({tag, "_no_bus"}, {31'h0, bus_req}, 32'd0);
        end
        check({tag, "_latency"}, {31'h0, resp_valid}, 32'd1);
        next_cycle();
        check({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'd0);
        check({tag, "_rdata_clr"}, rdata, 32'h0);
        check({tag, "_code_clr"}, {30'h0, err_code}, 32'h0);
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        check("rst_bus_req", {31'h0, bus_req}, 32'd0);
        check("rst_resp", {31'h0, resp_valid}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", {29'h0, err, err_code}, 32'h0);
        check("rst_bus_be", {28'h0, bus_be}, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        next_cycle();

        //      tag      mr    mw    st     lt      addr          wdata         bus_rdata    dly go  be       bus_wdata     rdata         code
        do_req("lb",    1'b1, 1'b0, 2'b00, 3'b011, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'b00);
        do_req("lhu",   1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 1, 1, 4'b1100, 32'h0,        32'h0000_BEEF, 2'b00);
        do_req("sb",    1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h0,        0, 1, 4'b0010, 32'hABAB_ABAB, 32'h0,        2'b00);
        do_req("sw_mis",1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_4002, 32'h1111_2222, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b01);
        do_req("sh",    1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_5002, 32'h9999_CAFE, 32'h0,        3, 1, 4'b1100, 32'hCAFE_CAFE, 32'h0,        2'b00);
        do_req("sw",    1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,        0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2'b00);
        do_req("lw",    1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_7004, 32'h0,        32'h1234_5678, 2, 1, 4'b1111, 32'h0,        32'h1234_5678, 2'b00);
        do_req("lh",    1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_7000, 32'h0,        32'h7777_8001, 0, 1, 4'b0011, 32'h0,        32'hFFFF_8001, 2'b00);
        do_req("lhu_lo",1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_7000, 32'h0,        32'h7777_8001, 0, 1, 4'b0011, 32'h0,        32'h0000_8001, 2'b00);
        do_req("lh_mis",1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_7001, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b01);
        do_req("st_ill",1'b0, 1'b1, 2'b11, 3'b000, 32'h0000_8000, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b11);
        do_req("ld_ill",1'b1, 1'b0, 2'b00, 3'b101, 32'h0000_8000, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b11);
        do_req("rw_ill",1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_8000, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b11);
        do_req("nop",   1'b0, 1'b0, 2'b00, 3'b000, 32'h0000_8003, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b00);

        // Every byte lane, unsigned then signed.
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'h0000_9000 + k;
            do_req("lbu_lane", 1'b1, 1'b0, 2'b00, 3'b100, a, 32'h0, 32'h4433_2211, 0, 1,
                   4'(1 << k), 32'h0, 32'(8'h11 * (k + 1)), 2'b00);
            do_req("lb_lane", 1'b1, 1'b0, 2'b00, 3'b011, a, 32'h0, 32'h8081_8283, 0, 1,
                   4'(1 << k), 32'h0, 32'hFFFF_FF83 - 32'(k), 2'b00);
        end

        // A stray ack while idle produces nothing.
        bus_ack = 1'b1;
        next_cycle();
        bus_ack = 1'b0;
        next_cycle();
        check("stray_ack_resp", {31'h0, resp_valid}, 32'd0);
        check("stray_ack_ready", {31'h0, req_ready}, 32'd1);

        // Reset while waiting for the bus aborts silently.
        req_valid = 1'b1; mem_read = 1'b1; load_type = 3'b000; addr = 32'h0000_A000;
        next_cycle();
        req_valid = 1'b0; mem_read = 1'b0;
        next_cycle();
        check("rst_mid_req", {31'h0, bus_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_drop", {31'h0, bus_req}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("rst_mid_ready", {31'h0, req_ready}, 32'd1);
            check("rst_mid_noresp", {31'h0, resp_valid}, 32'd0);
        end

`ifdef MEM_TIMEOUT_EN
        // No ack at all: bus_req for TIMEOUT_CYCLES cycles, then err_code 10.
        begin
            exp_t e;
            e.rdata = 32'h0; e.err = 1'b1; e.code = 2'b10;
            sb.push_back(e);
            req_valid = 1'b1; mem_read = 1'b1; load_type = 3'b000; addr = 32'h0000_B000;
            next_cycle();
            req_valid = 1'b0; mem_read = 1'b0;
            for (int i = 0; i < TO_CYC; i++) begin
                check("to_req_high", {31'h0, bus_req}, 32'd1);
                next_cycle();
            end
            check("to_req_drop", {31'h0, bus_req}, 32'd0);
            check("to_resp", {31'h0, resp_valid}, 32'd1);
            next_cycle();
            bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
            next_cycle();
            bus_ack = 1'b0;
            for (int i = 0; i < 3; i++) begin
                next_cycle();
                check("to_late_ack", {31'h0, resp_valid}, 32'd0);
            end
        end
`endif

        next_cycle();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
